// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Data-memory responder for the load/store path. It serves one
//            data SRAM request at a time with WAIT_CYCLES wait states, raises
//            a stall request while the access is pending, and returns a
//            registered 64-bit doubleword one cycle after the access edge.
// Option   : define DMEM_MISALIGN_CHK_EN to enable the byte-strobe alignment
//            check and the misalign_err pulse. Without it, misalign_err is 0.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        mem_stall,
  input  logic        data_sram_en,
  input  logic        data_sram_we,
  input  logic [7:0]  data_sram_sel,
  input  logic [63:0] data_sram_addr,
  input  logic [63:0] data_sram_wdata,
  output logic [63:0] data_sram_rdata,
  output logic        stallreq,
  output logic        misalign_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);
  localparam int         C_DEPTH = 1 << ADDR_W;

  logic [63:0]       r_mem [C_DEPTH];
  logic [0:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_err;
  logic [ADDR_W-1:0] w_index;
  logic              w_access;
  logic              w_misalign;

  // Doubleword index; address bits above the memory wrap silently.
  assign w_index = data_sram_addr[ADDR_W+2:3];

`ifdef DMEM_MISALIGN_CHK_EN
  logic [2:0] w_lowest;
  logic       w_shape_ok;
  logic       w_unused_ok;
  assign w_unused_ok = &{1'b0, data_sram_addr[63:ADDR_W+3]};

  // Legal strobe shapes whose lowest lane matches the byte offset.
  always_comb begin
    w_lowest = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (data_sram_sel[i]) w_lowest = 3'(i);
    end
    case (data_sram_sel)
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
      8'h03, 8'h0C, 8'h30, 8'hC0, 8'h0F, 8'hF0, 8'hFF: w_shape_ok = 1'b1;
      default:                                           w_shape_ok = 1'b0;
    endcase
    w_misalign = (data_sram_sel != 8'h00) &&
                 (!w_shape_ok || (w_lowest != data_sram_addr[2:0]));
  end
`else
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, data_sram_addr[63:ADDR_W+3], data_sram_addr[2:0]};
  assign w_misalign  = 1'b0;
`endif

  // Access edge: request present, nothing blocking, and the wait count is spent.
  always_comb begin
    w_access = 1'b0;
    if (!rst && !flush && !mem_stall && data_sram_en) begin
      case (r_state)
        S_IDLE:  w_access = (C_WAIT == 4'd0);
        S_WAIT:  w_access = (r_cnt == C_WAIT);
        default: w_access = 1'b0;
      endcase
    end
  end

  // Hold the request in EX until the cycle that owns the access edge.
  always_comb begin
    stallreq = 1'b0;
    if (!flush) begin
      case (r_state)
        S_IDLE:  stallreq = data_sram_en && !mem_stall && (C_WAIT != 4'd0);
        S_WAIT:  stallreq = (r_cnt != C_WAIT);
        default: stallreq = 1'b0;
      endcase
    end
  end

  // Byte-lane store into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_access && data_sram_we && !w_misalign) begin
      for (int i = 0; i < 8; i++) begin
        if (data_sram_sel[i]) r_mem[w_index][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  // Wait-state sequencer, read-data register and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= 4'd0;
      data_sram_rdata <= 64'd0;
      r_err           <= 1'b0;
    end else if (flush) begin
      r_state         <= S_IDLE;
      r_cnt           <= 4'd0;
      data_sram_rdata <= 64'd0;
      r_err           <= 1'b0;
    end else if (mem_stall) begin
      r_err <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (data_sram_en && (C_WAIT != 4'd0)) begin
            r_state <= S_WAIT;
            r_cnt   <= 4'd1;
          end
        end
        S_WAIT: begin
          if (!data_sram_en || (r_cnt == C_WAIT)) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
      if (w_access) begin
        if (w_misalign) begin
          data_sram_rdata <= 64'd0;
          r_err           <= 1'b1;
        end else if (data_sram_we) begin
          data_sram_rdata <= 64'd0;
        end else begin
          data_sram_rdata <= r_mem[w_index];
        end
      end
    end
  end

  assign misalign_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder. Four instances with
//            WAIT_CYCLES = 0..3 are exercised by directed steps and random
//            traffic against a doubleword-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int ADDR_W = 6;
  localparam int NDUT   = 4;

  logic        clk;
  logic        rst;
  logic        flush     [NDUT];
  logic        mem_stall [NDUT];
  logic        en        [NDUT];
  logic        we        [NDUT];
  logic [7:0]  sel       [NDUT];
  logic [63:0] addr      [NDUT];
  logic [63:0] wdata     [NDUT];
  logic [63:0] rdata     [NDUT];
  logic        stallreq  [NDUT];
  logic        err       [NDUT];

  logic [63:0] mdl     [NDUT][1 << ADDR_W];
  logic [63:0] last_rd [NDUT];
  logic [7:0]  legal_sel [15] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h03, 8'h0C, 8'h30, 8'hC0, 8'h0F, 8'hF0, 8'hFF};
  int n_assert = 0;
  int n_fail   = 0;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(k)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush[k]),
      .mem_stall      (mem_stall[k]),
      .data_sram_en   (en[k]),
      .data_sram_we   (we[k]),
      .data_sram_sel  (sel[k]),
      .data_sram_addr (addr[k]),
      .data_sram_wdata(wdata[k]),
      .data_sram_rdata(rdata[k]),
      .stallreq       (stallreq[k]),
      .misalign_err   (err[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  function automatic int lowest_lane(input logic [7:0] s);
    int lo = 0;
    for (int i = 7; i >= 0; i--) if (s[i]) lo = i;
    return lo;
  endfunction

  function automatic logic misaligned(input logic [7:0] s, input logic [63:0] a);
`ifdef DMEM_MISALIGN_CHK_EN
    if (s == 8'h00) return 1'b0;
    if (!(s inside {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                    8'h03, 8'h0C, 8'h30, 8'hC0, 8'h0F, 8'hF0, 8'hFF})) return 1'b1;
    return lowest_lane(s) != int'(a[2:0]);
`else
    return 1'b0;
`endif
  endfunction

  // One complete access on instance k; called and returning at posedge+1.
  task automatic access(input int k, input logic w, input logic [7:0] s,
                        input logic [63:0] a, input logic [63:0] d);
    logic [63:0] exp;
    logic        mis;
    int          idx;
    en[k] = 1'b1; we[k] = w; sel[k] = s; addr[k] = a; wdata[k] = d;
    for (int c = 0; c <= k; c++) begin
      #1;
      chk("stallreq", k, 64'(stallreq[k]), 64'(c < k));
      @(posedge clk); #1;
    end
    en[k] = 1'b0;
    mis = misaligned(s, a);
    idx = int'(a[ADDR_W+2:3]);
    if (mis) exp = 64'd0;
    else if (w) begin
      for (int i = 0; i < 8; i++) if (s[i]) mdl[k][idx][8*i +: 8] = d[8*i +: 8];
      exp = 64'd0;
    end else exp = mdl[k][idx];
    chk("rdata", k, rdata[k], exp);
    chk("misalign_err", k, 64'(err[k]), 64'(mis));
    last_rd[k] = exp;
  endtask

  // Idle cycles: read data holds and the error pulse has ended.
  task automatic idle(input int k, input int n);
    en[k] = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("rdata_hold", k, rdata[k], last_rd[k]);
      chk("err_clear", k, 64'(err[k]), 64'd0);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [63:0] a, d;
    logic [7:0]  s;
    rst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      flush[k] = 0; mem_stall[k] = 0; en[k] = 0; we[k] = 0;
      sel[k] = 0; addr[k] = 0; wdata[k] = 0; last_rd[k] = 0;
    end

    // Reset held two cycles.
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk("reset_rdata", k, rdata[k], 64'd0);
      chk("reset_stallreq", k, 64'(stallreq[k]), 64'd0);
      chk("reset_err", k, 64'(err[k]), 64'd0);
    end
    rst = 1'b0;

    // Fill every location with known data (upper address bits exercise wrap).
    for (int k = 0; k < NDUT; k++)
      for (int i = 0; i < (1 << ADDR_W); i++) begin
        a = rand64();
        a[ADDR_W+2:0] = {6'(i), 3'b000};
        access(k, 1'b1, 8'hFF, a, rand64());
      end

    // Zero wait states: store then immediate load.
    access(0, 1'b1, 8'hFF, 64'h10, 64'h1122334455667788);
    access(0, 1'b0, 8'hFF, 64'h10, 64'd0);
    chk("wc0_load", 0, rdata[0], 64'h1122334455667788);

    // Two wait states: byte merge into index 2.
    access(2, 1'b1, 8'hFF, 64'h10, 64'h1122334455667788);
    access(2, 1'b1, 8'h08, 64'h13, 64'h00000000AB000000);
    access(2, 1'b0, 8'hFF, 64'h10, 64'd0);
    chk("wc2_merge", 2, rdata[2], 64'h11223344AB667788);

    // Downstream hold with a store pending: no access, rdata frozen.
    mem_stall[2] = 1'b1;
    en[2] = 1'b1; we[2] = 1'b1; sel[2] = 8'hFF; addr[2] = 64'h10; wdata[2] = 64'hDEADBEEFCAFEF00D;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_hold", 2, rdata[2], last_rd[2]);
    end
    mem_stall[2] = 1'b0;
    idle(2, 1);
    access(2, 1'b0, 8'hFF, 64'h10, 64'd0);
    chk("stall_nowrite", 2, rdata[2], 64'h11223344AB667788);
    // Held load proceeds once the hold drops.
    mem_stall[2] = 1'b1;
    en[2] = 1'b1; we[2] = 1'b0; sel[2] = 8'hFF; addr[2] = 64'h18;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_hold2", 2, rdata[2], last_rd[2]);
    end
    mem_stall[2] = 1'b0;
    access(2, 1'b0, 8'hFF, 64'h18, 64'd0);

    // Three wait states: flush in the second wait cycle aborts a store.
    access(3, 1'b0, 8'hFF, 64'h28, 64'd0);
    en[3] = 1'b1; we[3] = 1'b1; sel[3] = 8'hFF; addr[3] = 64'h28; wdata[3] = 64'h0123456789ABCDEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush[3] = 1'b1;
    #1;
    chk("flush_stallreq", 3, 64'(stallreq[3]), 64'd0);
    @(posedge clk); #1;
    flush[3] = 1'b0; en[3] = 1'b0;
    chk("flush_rdata", 3, rdata[3], 64'd0);
    last_rd[3] = 64'd0;
    #1;
    chk("flush_idle", 3, 64'(stallreq[3]), 64'd0);
    access(3, 1'b0, 8'hFF, 64'h28, 64'd0);

    // Request withdrawn in WAIT: abort with no write and rdata unchanged.
    en[3] = 1'b1; we[3] = 1'b1; sel[3] = 8'hFF; addr[3] = 64'h30; wdata[3] = 64'h5555AAAA5555AAAA;
    @(posedge clk); #1;
    idle(3, 1);
    access(3, 1'b0, 8'hFF, 64'h30, 64'd0);

    // Alignment cases and sel=0.
    access(1, 1'b0, 8'h03, 64'h11, 64'd0);
    idle(1, 1);
    access(1, 1'b1, 8'h0C, 64'h12, 64'h0000_0000_7766_0000);
    access(1, 1'b0, 8'hFF, 64'h10, 64'd0);
    access(1, 1'b1, 8'h00, 64'h10, rand64());
    access(1, 1'b0, 8'h00, 64'h10, 64'd0);

    // Random traffic.
    for (int k = 0; k < NDUT; k++)
      for (int n = 0; n < 60; n++) begin
        a = rand64();
        d = rand64();
        if ($urandom_range(0, 1) == 1) begin
          s = legal_sel[$urandom_range(0, 14)];
          a[2:0] = 3'(lowest_lane(s));
        end else s = 8'($urandom);
        access(k, 1'($urandom_range(0, 1)), s, a, d);
        if ($urandom_range(0, 3) == 0) idle(k, $urandom_range(1, 2));
      end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the core's load/store path. It serves the data SRAM request driven from EX (enable, write, byte strobes, address, write data).
- It returns a registered 64-bit doubleword one cycle after the access edge, so the MEM stage extracts byte lanes from `data_sram_rdata`.
- It models configurable wait states and requests a pipeline stall while the access is pending.
- It holds read data stable while the pipeline is stalled downstream.

Parameters:
- ADDR_W, 12: doubleword index width; memory depth is 2^ADDR_W x 64 bits.
- WAIT_CYCLES, 1: extra cycles each access spends before its access edge (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- flush  in  1  pipeline flush; aborts a pending access.
- mem_stall  in  1  downstream hold (pipeline stall[3]); freezes rdata and blocks acceptance.
- data_sram_en  in  1  request valid.
- data_sram_we  in  1  1 = store, 0 = load.
- data_sram_sel  in  8  byte-lane strobes; bit i = byte i of the doubleword.
- data_sram_addr  in  64  byte address; index = addr[ADDR_W+2:3], upper bits ignored (wrap).
- data_sram_wdata  in  64  store data, lane-aligned.
- data_sram_rdata  out  64  registered load data.
- stallreq  out  1  combinational; holds the request in EX while the access is pending.
- misalign_err  out  1  registered error pulse (optional feature).

Behaviour:
- Reset (rst=1 at edge): state IDLE, cnt=0, data_sram_rdata=0, misalign_err=0. Memory contents are not reset. The output stallreq=0 follows because the state is IDLE.
- FSM states are IDLE and WAIT. cnt is 4 bits.
- IDLE, with en=1, mem_stall=0, flush=0:
  - WAIT_CYCLES=0: the access is performed at this edge; stallreq=0.
  - WAIT_CYCLES>0: stallreq=1; at the edge cnt<=1 and state<=WAIT; no access.
- WAIT:
  - stallreq = (cnt != WAIT_CYCLES).
  - While cnt<WAIT_CYCLES: cnt increments each edge.
  - At cnt==WAIT_CYCLES: stallreq=0, the access is performed at this edge, then cnt<=0 and state<=IDLE.
  - Each access therefore occupies EX for WAIT_CYCLES+1 cycles.
- Access edge, load: data_sram_rdata <= mem[index], the full doubleword regardless of sel. It is valid the cycle after the access edge, aligned with the MEM stage.
- Access edge, store: mem[index] byte i <= wdata byte i for each sel[i]=1. data_sram_rdata <= 0.
- Access edge, sel=0: a load still returns the doubleword; a store writes nothing.
- No access edge: data_sram_rdata holds its value.
- mem_stall=1: data_sram_rdata holds, no new request is accepted in IDLE, and a WAIT counter also freezes.
- flush=1 (and rst=0):
  - Next state IDLE, cnt=0; no write occurs even if this would be the access edge.
  - rdata <= 0; stallreq=0 that cycle.
- en dropping to 0 in WAIT: abort to IDLE with no access; rdata unchanged.
- Back-to-back accesses:
  - A store at edge N followed by a load to the same index presented after edge N returns the new data.
  - Single port, so there are no same-cycle conflicts.
- Priority: rst > flush > mem_stall > normal operation.

Optional Feature:
- Macro: DMEM_MISALIGN_CHK_EN.
- Defined: sel must be one of the following, otherwise the request is misaligned:
  - a single bit;
  - an aligned pair 0x03/0x0C/0x30/0xC0;
  - an aligned word 0x0F/0xF0;
  - the full doubleword 0xFF.
  - In addition, the index of the lowest set bit must equal addr[2:0].
- Defined, on a misaligned request at its access edge:
  - the write is suppressed and rdata <= 0;
  - misalign_err <= 1 for one cycle, aligned with rdata;
  - misalign_err <= 0 at every other edge.
- sel=0 is exempt from the check.
- Undefined: no check is made; misalign_err is tied 0.

Test Plan:
- Reset with WAIT_CYCLES=1, rst high 2 cycles -> rdata=0, stallreq=0, misalign_err=0.
- WAIT_CYCLES=0: store addr=0x10, sel=0xFF, wdata=0x1122334455667788; load addr=0x10 next cycle -> rdata=0x1122334455667788 one cycle after the load edge; stallreq never 1.
- WAIT_CYCLES=2: byte store addr=0x13, sel=0x08, wdata=0xAB000000 over 0x1122334455667788 at index 2; then a load at 0x10 -> stallreq high 2 cycles for each access; rdata=0x11223344AB667788.
- Load completes, then mem_stall=1 for 3 cycles with new addr/en present -> rdata holds the old value and no access occurs; the access proceeds after mem_stall drops.
- WAIT_CYCLES=3: store issued, flush pulsed in the second WAIT cycle -> state IDLE, stallreq=0, memory unchanged, rdata=0.
- Feature on: load addr=0x11, sel=0x03 -> misalign_err=1 for one cycle, rdata=0; store addr=0x12, sel=0x0C accepted, misalign_err=0.
